// File: rtl/coffee_dispenser_ctrl_if.sv
// Bundle of the dispenser's command, sensor and drive signals.
// The controller uses the slave modport; the machine side uses the master modport.
interface coffee_dispenser_ctrl_if #(
  parameter int SEL_W = 2
);
  logic                  START;
  logic [SEL_W-1:0]      SEL;
  logic                  SR;
  logic                  SP;
  logic                  SN;
  logic                  A;
  logic                  VL;
  logic [4:0]            ERR;
  logic [2**SEL_W-1:0]   SEL_LED;
  logic                  AQ;
  logic                  PP;
  logic                  P;
  logic                  M;
  logic                  BUSY;
  logic                  DONE;

  modport master (
    output START, SEL, SR, SP, SN, A, VL,
    input  ERR, SEL_LED, AQ, PP, P, M, BUSY, DONE
  );

  modport slave (
    input  START, SEL, SR, SP, SN, A, VL,
    output ERR, SEL_LED, AQ, PP, P, M, BUSY, DONE
  );
endinterface

// File: rtl/coffee_dispenser_ctrl.sv
// Brew sequencer: heat -> powder -> pour (recipe-scaled) -> mix -> finish,
// with sensor-driven aborts into a sticky-error FAULT state.
module coffee_dispenser_ctrl #(
  parameter int SEL_W      = 2,
  parameter int HEAT_CYC   = 8,
  parameter int POWDER_CYC = 4,
  parameter int POUR_BASE  = 10,
  parameter int MIX_CYC    = 6,
  parameter int CNT_W      = 16
) (
  input logic                    CLK,
  input logic                    RST_N,
  coffee_dispenser_ctrl_if.slave bus
);

  localparam int NREC = 2**SEL_W;
  localparam logic [63:0] POUR_MAX = 64'(POUR_BASE) * 64'(NREC);
  localparam logic [63:0] CNT_LIM  = (64'd1 << CNT_W) - 64'd1;

  generate
    if (HEAT_CYC == 0 || POWDER_CYC == 0 || POUR_BASE == 0 || MIX_CYC == 0) begin : g_zero_phase
      $error("coffee_dispenser_ctrl: phase length parameters must be non-zero");
    end
    if (POUR_MAX > CNT_LIM) begin : g_pour_overflow
      $error("coffee_dispenser_ctrl: longest pour does not fit in CNT_W bits");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAT,
    S_POWDER,
    S_POUR,
    S_MIX,
    S_FIN,
    S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [4:0]        err_q, err_d;
  logic [4:0]        sens_n;
  logic              sensors_ok;
  logic              phase_end;
  logic              busy_d;
  logic [NREC-1:0]   led_onehot;
  logic [NREC-1:0]   led_q;
  logic              aq_q, pp_q, p_q, m_q, busy_q, done_q;

  assign sens_n     = ~{bus.VL, bus.A, bus.SN, bus.SP, bus.SR};
  assign sensors_ok = (sens_n == 5'b00000);
  assign phase_end  = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = sens_n;

    // Aborts are checked before phase completion so they win on the last cycle.
    unique case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          if (sensors_ok) begin
            state_d = S_HEAT;
            sel_d   = bus.SEL;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_HEAT: begin
        if (!bus.VL || !bus.A)  state_d = S_FAULT;
        else if (phase_end)     state_d = S_POWDER;
      end
      S_POWDER: begin
        if (!bus.VL)            state_d = S_FAULT;
        else if (phase_end)     state_d = S_POUR;
      end
      S_POUR: begin
        if (!bus.VL || !bus.A)  state_d = S_FAULT;
        else if (phase_end)     state_d = S_MIX;
      end
      S_MIX: begin
        if (!bus.VL)            state_d = S_FAULT;
        else if (phase_end)     state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      S_FAULT: begin
        if (sensors_ok && !bus.START) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_q == S_FAULT) begin
      err_d = (state_d == S_IDLE) ? 5'b00000 : (err_q | sens_n);
    end

    // Timer holds cycles remaining minus one, reloaded on every state change.
    if (state_d != state_q) begin
      unique case (state_d)
        S_HEAT:   cnt_d = CNT_W'(HEAT_CYC - 1);
        S_POWDER: cnt_d = CNT_W'(POWDER_CYC - 1);
        S_POUR:   cnt_d = CNT_W'(POUR_BASE) * (CNT_W'(sel_d) + CNT_W'(1)) - CNT_W'(1);
        S_MIX:    cnt_d = CNT_W'(MIX_CYC - 1);
        default:  cnt_d = '0;
      endcase
    end else if (!phase_end) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    busy_d = (state_d == S_HEAT) || (state_d == S_POWDER) || (state_d == S_POUR) ||
             (state_d == S_MIX)  || (state_d == S_FIN);
  end

  generate
    for (genvar gi = 0; gi < NREC; gi++) begin : g_led
      assign led_onehot[gi] = (sel_d == SEL_W'(gi));
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      err_q   <= '0;
      led_q   <= '0;
      aq_q    <= 1'b0;
      pp_q    <= 1'b0;
      p_q     <= 1'b0;
      m_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      led_q   <= busy_d ? led_onehot : '0;
      aq_q    <= (state_d == S_HEAT);
      pp_q    <= (state_d == S_POWDER);
      p_q     <= (state_d == S_POUR);
      m_q     <= (state_d == S_MIX);
      busy_q  <= busy_d;
      done_q  <= (state_d == S_FIN);
    end
  end

  assign bus.ERR     = err_q;
  assign bus.SEL_LED = led_q;
  assign bus.AQ      = aq_q;
  assign bus.PP      = pp_q;
  assign bus.P       = p_q;
  assign bus.M       = m_q;
  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;

endmodule

// File: tb/tb_coffee_dispenser_ctrl.sv
// Directed bench for coffee_dispenser_ctrl with default parameters.
// Outputs are sampled on the falling edge; cycle c means c rising edges after START was taken.
module tb_coffee_dispenser_ctrl;

  logic CLK;
  logic RST_N;
  int   vectors;
  int   miscompares;

  coffee_dispenser_ctrl_if #(.SEL_W(2)) bus ();

  coffee_dispenser_ctrl #(
    .SEL_W(2), .HEAT_CYC(8), .POWDER_CYC(4), .POUR_BASE(10), .MIX_CYC(6), .CNT_W(16)
  ) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {AQ,PP,P,M,BUSY,DONE,SEL_LED}
  function automatic logic [15:0] outs();
    return {6'b0, bus.AQ, bus.PP, bus.P, bus.M, bus.BUSY, bus.DONE, bus.SEL_LED};
  endfunction

  // Expected drives at brew cycle c for a pour of pl cycles.
  function automatic logic [15:0] exp_at(input int c, input int pl, input logic [3:0] led);
    int pe, me, f;
    logic aq, pp, p, m, busy, dn;
    pe   = 12 + pl;
    me   = pe + 6;
    f    = me + 1;
    aq   = (c >= 1)  && (c <= 8);
    pp   = (c >= 9)  && (c <= 12);
    p    = (c >= 13) && (c <= pe);
    m    = (c > pe)  && (c <= me);
    dn   = (c == f);
    busy = (c >= 1)  && (c <= f);
    return {6'b0, aq, pp, p, m, busy, dn, (busy ? led : 4'b0000)};
  endfunction

  initial begin
    vectors     = 0;
    miscompares = 0;
    RST_N       = 1'b0;
    bus.START   = 1'b0;
    bus.SEL     = 2'd0;
    bus.SR      = 1'b1;
    bus.SP      = 1'b1;
    bus.SN      = 1'b1;
    bus.A       = 1'b1;
    bus.VL      = 1'b1;

    // Reset state
    @(negedge CLK);
    chk("reset_outs", outs(), 16'h0000);
    chk("reset_err", {11'b0, bus.ERR}, 16'h0000);

    // Brew straight out of reset with START already high, SEL=0
    bus.START = 1'b1;
    RST_N     = 1'b1;
    step();
    for (int c = 1; c <= 30; c++) begin
      chk($sformatf("post_reset_brew_c%0d", c), outs(), exp_at(c, 10, 4'b0001));
      if (c == 1) bus.START = 1'b0;
      if (c < 30) step();
    end

    // Normal brew SEL=2: pour 30 cycles, DONE at cycle 49
    bus.SEL   = 2'd2;
    bus.START = 1'b1;
    step();
    for (int c = 1; c <= 50; c++) begin
      chk($sformatf("brew_sel2_c%0d", c), outs(), exp_at(c, 30, 4'b0100));
      if (c == 1) bus.START = 1'b0;
      if (c < 50) step();
    end

    // START with SN missing -> FAULT, then recover
    bus.SN    = 1'b0;
    bus.START = 1'b1;
    step();
    chk("sn_fault_outs", outs(), 16'h0000);
    chk("sn_fault_err", {11'b0, bus.ERR}, 16'h0004);
    bus.START = 1'b0;
    step();
    chk("sn_fault_hold_err", {11'b0, bus.ERR}, 16'h0004);
    bus.SN = 1'b1;
    step();
    chk("sn_recover_err", {11'b0, bus.ERR}, 16'h0000);

    // VL lost on 5th pour cycle (cycle 17) with SEL=0
    bus.SEL   = 2'd0;
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int c = 1; c < 17; c++) step();
    chk("vl_pour5_p", outs(), exp_at(17, 10, 4'b0001));
    bus.VL = 1'b0;
    step();
    chk("vl_abort_outs", outs(), 16'h0000);
    chk("vl_abort_err", {11'b0, bus.ERR}, 16'h0010);
    bus.VL    = 1'b1;
    bus.START = 1'b1;
    step();
    chk("vl_sticky_err", {11'b0, bus.ERR}, 16'h0010);
    bus.SR = 1'b0;
    step();
    chk("vl_sticky_accum_err", {11'b0, bus.ERR}, 16'h0011);
    bus.SR    = 1'b1;
    bus.START = 1'b0;
    step();
    chk("vl_fault_exit_err", {11'b0, bus.ERR}, 16'h0000);
    chk("vl_fault_exit_outs", outs(), 16'h0000);

    // A drop coincides with last HEAT cycle -> FAULT, PP never asserts
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    for (int c = 1; c < 8; c++) step();
    chk("heat_last_outs", outs(), exp_at(8, 10, 4'b0001));
    bus.A = 1'b0;
    step();
    chk("heat_abort_outs", outs(), 16'h0000);
    chk("heat_abort_err", {11'b0, bus.ERR}, 16'h0008);
    bus.A = 1'b1;
    step();
    chk("heat_abort_exit_outs", outs(), 16'h0000);
    chk("heat_abort_exit_err", {11'b0, bus.ERR}, 16'h0000);

    // Non-aborting sensor loss: A during POWDER, SR during POUR
    bus.START = 1'b1;
    step();
    for (int c = 1; c <= 30; c++) begin
      chk($sformatf("nonabort_c%0d", c), outs(), exp_at(c, 10, 4'b0001));
      if (c == 1) bus.START = 1'b0;
      if (c == 10) bus.A = 1'b0;
      if (c == 11) begin
        chk("powder_a_err", {11'b0, bus.ERR}, 16'h0008);
        bus.A = 1'b1;
      end
      if (c == 13) bus.SR = 1'b0;
      if (c == 14) begin
        chk("pour_sr_err", {11'b0, bus.ERR}, 16'h0001);
        bus.SR = 1'b1;
      end
      if (c < 30) step();
    end

    // START held high, SEL 1->3 during HEAT: pour stays 20, rebrew after FIN
    bus.SEL   = 2'd1;
    bus.START = 1'b1;
    step();
    for (int c = 1; c <= 41; c++) begin
      if (c <= 40)
        chk($sformatf("held_start_c%0d", c), outs(), exp_at(c, 20, 4'b0010));
      else
        chk("held_start_rebrew", outs(), exp_at(1, 40, 4'b1000));
      if (c == 3) bus.SEL = 2'd3;
      if (c < 41) step();
    end
    bus.START = 1'b0;

    // Asynchronous reset mid-POUR of the SEL=3 brew (brew cycle 15)
    for (int c = 2; c <= 15; c++) step();
    chk("pre_reset_pour", outs(), exp_at(15, 40, 4'b1000));
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_reset_outs", outs(), 16'h0000);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
    chk("after_reset_outs", outs(), 16'h0000);
    chk("after_reset_err", {11'b0, bus.ERR}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/coffee_dispenser_ctrl.md
COFFEE_DISPENSER_CTRL -- requirements
Module: coffee_dispenser_ctrl

Interface
REQ-001 SHALL have parameter SEL_W, default 2, recipe-select width (2**SEL_W recipes).
REQ-002 SHALL have parameter HEAT_CYC, default 8, heater phase length in cycles.
REQ-003 SHALL have parameter POWDER_CYC, default 4, powder phase length in cycles.
REQ-004 SHALL have parameter POUR_BASE, default 10, pour cycles per recipe step.
REQ-005 SHALL have parameter MIX_CYC, default 6, mixer phase length in cycles.
REQ-006 SHALL have parameter CNT_W, default 16, phase timer width.
REQ-007 SHALL have port CLK  input  1  the single clock; all state changes on its rising edge.
REQ-008 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-009 SHALL have port START  input  1  brew request, level-sampled in IDLE.
REQ-010 SHALL have port SEL  input  SEL_W  recipe index.
REQ-011 SHALL have ports SR, SP, SN  input  1 each  ingredient-present sensors (1 = present).
REQ-012 SHALL have ports A and VL  input  1 each  water present and cup present.
REQ-013 SHALL have port ERR  output  5  fault flags {~VL, ~A, ~SN, ~SP, ~SR}, bit 0 = SR.
REQ-014 SHALL have port SEL_LED  output  2**SEL_W  one-hot latched recipe, 0 when idle.
REQ-015 SHALL have ports AQ, PP, P, M  output  1 each  heater, powder, pump, mixer drives.
REQ-016 SHALL have ports BUSY and DONE  output  1 each  brew in progress; one-cycle completion pulse.

Function
REQ-017 SHALL implement states IDLE, HEAT, POWDER, POUR, MIX, FIN, FAULT, held in a registered state machine.
REQ-018 SHALL define sensors OK as SR&SP&SN&A&VL.
REQ-019 IDLE: START=1 and OK -> HEAT and latch SEL; START=1 and not OK -> FAULT; START=0 -> stay.
REQ-020 HEAT SHALL last HEAT_CYC cycles, then POWDER; POWDER SHALL last POWDER_CYC cycles, then POUR.
REQ-021 POUR SHALL last POUR_BASE*(latched SEL+1) cycles, then MIX; MIX SHALL last MIX_CYC cycles, then FIN.
REQ-022 FIN SHALL last exactly one cycle, then IDLE.
REQ-023 Phase timer SHALL reload on every state entry; the product in REQ-021 SHALL be computed in CNT_W bits and elaboration SHALL fail if POUR_BASE*2**SEL_W exceeds 2**CNT_W-1 or any phase parameter is 0.
REQ-024 Abort: VL=0 in HEAT/POWDER/POUR/MIX, or A=0 in HEAT/POUR, SHALL move to FAULT at the next edge; abort SHALL take priority over phase completion in the same cycle.
REQ-025 FAULT SHALL return to IDLE at the first edge where OK=1 and START=0.
REQ-026 Outputs SHALL be Moore-decoded from registered state only: AQ=HEAT, PP=POWDER, P=POUR, M=MIX, DONE=FIN, BUSY=HEAT|POWDER|POUR|MIX|FIN.
REQ-027 ERR SHALL be a register loaded each cycle with inverted sensors, except in FAULT where each bit SHALL be sticky (OR-accumulated) and cleared on FAULT->IDLE.
REQ-028 SEL_LED SHALL show one-hot of latched SEL while BUSY, else 0.
REQ-029 START and SEL SHALL be ignored outside IDLE; START held high SHALL start a new brew only after FIN returns to IDLE.
REQ-030 Sensor loss in a phase not listed in REQ-024 (e.g. SR during POUR) SHALL NOT abort; it SHALL appear only in ERR.

Reset
REQ-031 RST_N=0 SHALL immediately force state IDLE, timer 0, latched SEL 0, ERR 0, and AQ, PP, P, M, BUSY, DONE, SEL_LED all 0, regardless of current state.
REQ-032 Leaving reset SHALL require no START edge; START high at first active edge with OK SHALL begin a brew.

Verification
REQ-033 Reset: RST_N low mid-POUR -> P, BUSY, SEL_LED drop to 0 without a clock edge; after release state IDLE, ERR=00000.
REQ-034 Normal brew, defaults, SEL=2, all sensors 1, START pulse at edge t0 -> AQ high cycles 1-8, PP 9-12, P 13-42, M 43-48, DONE 49 only, SEL_LED=0100 cycles 1-49.
REQ-035 START with SN=0 -> FAULT, no actuator high, ERR=00100; set SN=1, START=0 -> IDLE next edge, ERR=00000.
REQ-036 VL dropped at 5th POUR cycle, SEL=0 -> P low after next edge, state FAULT, ERR[4]=1 sticky after VL restored until exit.
REQ-037 START held high, SEL changed 1->3 during HEAT -> pour lasts 20 cycles, exactly one DONE, second brew starts the cycle after FIN.
REQ-038 A and timer expiry coincide at last HEAT cycle (A=0) -> FAULT, PP never asserts.
